md_unit: RTL

- Multi-cycle multiply/divide unit in the EX stage, with architectural HI/LO registers.
- Executes MIPS mult/multu/div/divu/mthi/mtlo.
- HI and LO feed the EX result-select mux (selects 3 and 4). Busy feeds the hazard unit, which stalls HI/LO-dependent instructions.
- Operands arrive already forwarded (post ALU-source mux).

---
 rtl/md_unit.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module      : md_unit
//  Description : Multi-cycle multiply/divide unit for the EX stage, holding
//                the architectural HI/LO registers. Executes mult, multu,
//                div, divu (multi-cycle, Start-qualified) and mthi, mtlo
//                (single cycle, no Start required).
//                Optional multiply-accumulate ops (madd, maddu, msub, msubu)
//                are built only when the macro MD_MADD_EN is defined.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk    in   1   system clock, rising edge
//    reset  in   1   synchronous, active-high
//    A      in  32   operand rs (already forwarded)
//    B      in  32   operand rt (already forwarded)
//    MDOp   in   4   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//                    7 madd, 8 maddu, 9 msub, 10 msubu (7-10 need MD_MADD_EN)
//    Start  in   1   qualifies MDOp for the multi-cycle ops
//    HI     out 32   HI register
//    LO     out 32   LO register
//    Busy   out  1   operation in flight (hazard unit stalls HI/LO readers)
//  Parameters
//    MULT_CYCLES  busy duration of multiply-class ops (>= 1)
//    DIV_CYCLES   busy duration of divide-class ops (>= 1)
// ============================================================================
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDOp,
    input  logic        Start,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    localparam logic [31:0] MULT_LOAD = 32'(MULT_CYCLES);
    localparam logic [31:0] DIV_LOAD  = 32'(DIV_CYCLES);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  op_code;
    logic [31:0] cnt;

    logic        is_mul_op;
    logic        is_div_op;
    logic        accept;
    logic        finish;

    // ------------------------------------------------------------------
    // Opcode classification of the incoming request
    // ------------------------------------------------------------------
    always_comb begin
        is_mul_op = (MDOp == OP_MULT) || (MDOp == OP_MULTU);
`ifdef MD_MADD_EN
        is_mul_op = is_mul_op || (MDOp == OP_MADD) || (MDOp == OP_MADDU) ||
                    (MDOp == OP_MSUB) || (MDOp == OP_MSUBU);
`endif
        is_div_op = (MDOp == OP_DIV) || (MDOp == OP_DIVU);
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start && (is_mul_op || is_div_op)) begin
                    accept     = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                // Counter holds the number of busy cycles still to go,
                // including the current one.
                if (cnt == 32'd1) begin
                    finish     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign Busy = (state == S_RUN);

    // ------------------------------------------------------------------
    // Result datapath, evaluated from the latched operands. HI/LO cannot
    // change while RUN, so the accumulate base seen here equals the value
    // at the accepting edge.
    // ------------------------------------------------------------------
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               div_signed;
    logic               a_neg;
    logic               b_neg;
    logic        [31:0] a_mag;
    logic        [31:0] b_mag;
    logic        [31:0] divisor;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;
    logic        [31:0] quo;
    logic        [31:0] rem;
    logic        [63:0] result;
    logic               commit;

    always_comb begin
        prod_s = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
        prod_u = {32'd0, op_a} * {32'd0, op_b};

        // Signed divide via magnitudes: truncation toward zero falls out
        // naturally and 0x80000000 / -1 wraps to 0x80000000 with rem 0.
        div_signed = (op_code == OP_DIV);
        a_neg      = div_signed & op_a[31];
        b_neg      = div_signed & op_b[31];
        a_mag      = a_neg ? (~op_a + 32'd1) : op_a;
        b_mag      = b_neg ? (~op_b + 32'd1) : op_b;
        // Divide by zero never commits; substitute 1 to keep the divider defined.
        divisor    = (op_b == 32'd0) ? 32'd1 : b_mag;
        quo_u      = a_mag / divisor;
        rem_u      = a_mag % divisor;
        quo        = (a_neg ^ b_neg) ? (~quo_u + 32'd1) : quo_u;
        rem        = a_neg ? (~rem_u + 32'd1) : rem_u;

        case (op_code)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV,
            OP_DIVU:  result = {rem, quo};
`ifdef MD_MADD_EN
            OP_MADD:  result = {HI, LO} + prod_s;
            OP_MADDU: result = {HI, LO} + prod_u;
            OP_MSUB:  result = {HI, LO} - prod_s;
            OP_MSUBU: result = {HI, LO} - prod_u;
`endif
            default:  result = {HI, LO};
        endcase

        commit = !(((op_code == OP_DIV) || (op_code == OP_DIVU)) && (op_b == 32'd0));
    end

    // ------------------------------------------------------------------
    // Operand latches, busy counter and architectural HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a    <= 32'd0;
            op_b    <= 32'd0;
            op_code <= 4'd0;
            cnt     <= 32'd0;
            HI      <= 32'd0;
            LO      <= 32'd0;
        end else if (accept) begin
            op_a    <= A;
            op_b    <= B;
            op_code <= MDOp;
            cnt     <= is_div_op ? DIV_LOAD : MULT_LOAD;
        end else if (finish) begin
            cnt <= 32'd0;
            if (commit) begin
                HI <= result[63:32];
                LO <= result[31:0];
            end
        end else if (state == S_RUN) begin
            cnt <= cnt - 32'd1;
        end else if (MDOp == OP_MTHI) begin
            HI <= A;
        end else if (MDOp == OP_MTLO) begin
            LO <= A;
        end
    end

endmodule
`default_nettype wire
